bin2bcd_serial: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method.
- Sits directly downstream of the serial divider. Consumes its W-bit quotient and valid flag, and produces packed BCD digits for the display/readout stage.
- Processes one bit per clock, matching the divider's serial, low-area style.

---
 rtl/bin2bcd_serial.sv | 105 ++++++++++
 tb/tb_bin2bcd_serial.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter, one bit per clock (W shifts + 1 done cycle).
// Optional leading-zero blanking mask enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_serial #(
  parameter int W      = 26,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [W-1:0]          bin_in,
  output logic                  busy,
  output logic                  bcd_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_blank
);

  localparam int CW = $clog2(W+1);
  localparam int BW = 4*DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    bin_sh;
  logic [BW-1:0]   bcd_sh;
  logic [BW-1:0]   bcd_adj;
  logic [CW-1:0]   cnt;
  logic            last_shift;

  assign last_shift = (cnt == CW'(W-1));
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-digit add-3 on the pre-shift value; 4-bit wrap is harmless for legal DIGITS.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    logic [3:0] d;
    assign d                = bcd_sh[4*g +: 4];
    assign bcd_adj[4*g +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sh    <= '0;
      bcd_sh    <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          bin_sh <= bin_in;
          bcd_sh <= '0;
          cnt    <= '0;
        end
        SHIFT: begin
          bcd_sh <= {bcd_adj[BW-2:0], bin_sh[W-1]};
          bin_sh <= {bin_sh[W-2:0], 1'b0};
          cnt    <= cnt + CW'(1);
        end
        DONE: begin
          bcd_out   <= bcd_sh;
          bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;

  // Blank digit i when it and every digit above it is zero; units digit always shown.
  always_comb begin
    logic zero_above;
    blank_nxt  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      zero_above   = zero_above & (bcd_sh[4*i +: 4] == 4'd0);
      blank_nxt[i] = zero_above;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                digit_blank <= '0;
    else if (state == DONE) digit_blank <= blank_nxt;
  end
`else
  assign digit_blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Directed bench for bin2bcd_serial: latency, values, back-to-back rearm, reset abort, blanking.
module tb_bin2bcd_serial;

  localparam int W      = 26;
  localparam int DIGITS = 8;
  localparam int LAT    = W + 1;
`ifdef BIN2BCD_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic [W-1:0]        bin_in;
  logic                busy;
  logic                bcd_valid;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   digit_blank;

  int checks = 0;
  int errors = 0;
  int n;
  bit bok;

  bin2bcd_serial #(.W(W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bin_in(bin_in),
    .busy(busy), .bcd_valid(bcd_valid), .bcd_out(bcd_out), .digit_blank(digit_blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bmask(input logic [7:0] m);
    return BLANK ? m : 8'h00;
  endfunction

  // Waits (bounded) for bcd_valid; n = edges taken, ok = busy stayed high before it.
  task automatic wait_valid(output int cnt, output bit ok);
    cnt = 0;
    ok  = 1'b1;
    do begin
      @(posedge clk); #1;
      cnt++;
      if (!bcd_valid && !busy) ok = 1'b0;
    end while (!bcd_valid && cnt < 60);
  endtask

  // Called at posedge+1 with the DUT idle; ends at posedge+1 one cycle after the result.
  task automatic run_conv(input string tag, input logic [W-1:0] v,
                          input logic [31:0] exp_bcd, input logic [7:0] exp_blank);
    bin_in   = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " busy_after_capture"}, busy, 1);
    wait_valid(n, bok);
    chk({tag, " latency"}, n, LAT);
    chk({tag, " busy_held"}, bok, 1);
    chk({tag, " bcd_out"}, bcd_out, exp_bcd);
    chk({tag, " digit_blank"}, digit_blank, bmask(exp_blank));
    chk({tag, " busy_low_at_done"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, " valid_one_cycle"}, bcd_valid, 0);
    chk({tag, " bcd_out_hold"}, bcd_out, exp_bcd);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    bin_in   = '0;
    #12;
    chk("reset busy", busy, 0);
    chk("reset bcd_valid", bcd_valid, 0);
    chk("reset bcd_out", bcd_out, 0);
    chk("reset digit_blank", digit_blank, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_conv("zero", 26'd0, 32'h00000000, 8'b11111110);
    run_conv("mid", 26'd12345678, 32'h12345678, 8'b00000000);
    run_conv("max", 26'd67108863, 32'h67108863, 8'b00000000);

    // Back-to-back with in_valid held high; bin_in changes mid-conversion.
    bin_in   = 26'd99;
    in_valid = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    bin_in = 26'd500;
    chk("held out_hold_in_shift", bcd_out, 32'h67108863);
    chk("held valid_low_in_shift", bcd_valid, 0);
    wait_valid(n, bok);
    chk("held first latency", n, LAT - 10);
    chk("held first bcd_out", bcd_out, 32'h00000099);
    chk("held first blank", digit_blank, bmask(8'b11111100));
    @(posedge clk); #1;
    chk("held rearm busy", busy, 1);
    chk("held rearm valid_low", bcd_valid, 0);
    in_valid = 1'b0;
    wait_valid(n, bok);
    chk("held second latency", n, LAT);
    chk("held second busy_held", bok, 1);
    chk("held second bcd_out", bcd_out, 32'h00000500);
    chk("held second blank", digit_blank, bmask(8'b11111000));
    @(posedge clk); #1;
    chk("held no_third busy", busy, 0);

    run_conv("b305", 26'd305, 32'h00000305, 8'b11111000);
    run_conv("b42", 26'd42, 32'h00000042, 8'b11111100);

    // Abort a conversion with reset partway through the shift phase.
    bin_in   = 26'd12345;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (13) begin @(posedge clk); #1; end
    chk("abort pre busy", busy, 1);
    chk("abort pre bcd_out", bcd_out, 32'h00000042);
    rst = 1'b1;
    #1;
    chk("abort bcd_out", bcd_out, 0);
    chk("abort busy", busy, 0);
    chk("abort bcd_valid", bcd_valid, 0);
    chk("abort digit_blank", digit_blank, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_conv("post_reset7", 26'd7, 32'h00000007, 8'b11111110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
